// File: rtl/flag_sequencer.sv
// -----------------------------------------------------------------------------
// flag_sequencer
//   Sequences per-stage completion flags (BIST, RAM, CONFIG, LOAD, ...) from
//   command bytes strobed by i_done. Stages must complete in order. A done code
//   that arrives out of order, or any stage fail code, latches an error. Every
//   accepted event produces one status word, which is sent over a one-deep
//   valid/ready link toward the Ethernet reporting path.
//
//   Ports
//     i_clk           rising-edge clock
//     i_rst_n         asynchronous active-low reset (asserts immediately,
//                     releases synchronously)
//     i_data[7:0]     command byte, sampled only while i_done=1
//     i_done          command strobe, one byte per cycle
//     i_clear         synchronous restart of the sequence; wins over i_done
//     o_flags[N-1:0]  per-stage done flags (bit i = stage i)
//     o_all_done      every stage completed in order (level)
//     o_err           sequence or stage failure latched
//     o_err_stage     stage index at which o_err was raised (zero-extended)
//     o_status        {STATUS_HDR, onehot[N-1:0], code[3:0]}
//     o_status_valid  status word pending
//     i_status_ready  consumer takes the word when valid & ready
//     o_status_ovf    sticky: at least one event's status word was dropped
//
//   Status codes: A = in-order done, E = out-of-order done,
//                 5 = stage fail, unknown byte, or strobe after completion.
// -----------------------------------------------------------------------------

// Per-stage cell. It decodes its own done and fail codes and holds the
// stage flag.
module flag_sequencer_lane #(
  parameter int         LANE      = 0,
  parameter logic [7:0] DONE_BASE = 8'h52,
  parameter logic [7:0] FAIL_BASE = 8'h56,
  parameter bit         STICKY    = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_clear,
  input  logic       i_set,
  output logic       o_is_done,
  output logic       o_is_fail,
  output logic       o_flag
);
  localparam logic [7:0] DCODE = DONE_BASE + 8'(LANE);
  localparam logic [7:0] FCODE = FAIL_BASE + 8'(LANE);

  logic r_flag;

  assign o_is_done = (i_data == DCODE);
  assign o_is_fail = (i_data == FCODE);
  assign o_flag    = r_flag;

  // In pulse mode the flag is high only for the cycle after its accepted done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_flag <= 1'b0;
    else if (i_clear) r_flag <= 1'b0;
    else if (i_set)   r_flag <= 1'b1;
    else if (!STICKY) r_flag <= 1'b0;
  end
endmodule

module flag_sequencer #(
  parameter int         N_FLAGS    = 4,
  parameter logic [7:0] DONE_BASE  = 8'h52,
  parameter logic [7:0] FAIL_BASE  = 8'h56,
  parameter logic [7:0] STATUS_HDR = 8'h01,
  parameter bit         STICKY     = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_data,
  input  logic                 i_done,
  input  logic                 i_clear,
  output logic [N_FLAGS-1:0]   o_flags,
  output logic                 o_all_done,
  output logic                 o_err,
  output logic [2:0]           o_err_stage,
  output logic [12+N_FLAGS-1:0] o_status,
  output logic                 o_status_valid,
  input  logic                 i_status_ready,
  output logic                 o_status_ovf
);
  // The stage counter must reach N_FLAGS once the last stage completes, so it
  // has one value more than the stage indices.
  localparam int SW = $clog2(N_FLAGS + 1);
  localparam int STW = 12 + N_FLAGS;
  localparam logic [SW-1:0]      STAGE_LAST = SW'(N_FLAGS - 1);
  localparam logic [N_FLAGS-1:0] ONE_N      = N_FLAGS'(1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_COMPLETE = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Reset synchroniser. Assertion is asynchronous. Release waits for two edges.
  // ---------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // ---------------------------------------------------------------------------
  // Per-stage lanes: code decode and flag storage
  // ---------------------------------------------------------------------------
  logic [N_FLAGS-1:0] w_done_vec, w_fail_vec, w_set, w_flags;

  for (genvar g = 0; g < N_FLAGS; g++) begin : g_lane
    flag_sequencer_lane #(
      .LANE      (g),
      .DONE_BASE (DONE_BASE),
      .FAIL_BASE (FAIL_BASE),
      .STICKY    (STICKY)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst_n   (w_rst_n),
      .i_data    (i_data),
      .i_clear   (i_clear),
      .i_set     (w_set[g]),
      .o_is_done (w_done_vec[g]),
      .o_is_fail (w_fail_vec[g]),
      .o_flag    (w_flags[g])
    );
  end

  logic       w_done_hit, w_fail_hit;
  logic [2:0] w_fail_idx;

  assign w_done_hit = |w_done_vec;
  assign w_fail_hit = |w_fail_vec;

  always_comb begin
    w_fail_idx = 3'd0;
    for (int i = 0; i < N_FLAGS; i++)
      if (w_fail_vec[i]) w_fail_idx = 3'(i);
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_stage, w_stage_nxt;
  logic [N_FLAGS-1:0] w_stage_oh;
  logic            w_inorder;

  logic            w_evt;
  logic [N_FLAGS-1:0] w_evt_oh;
  logic [3:0]      w_evt_code;
  logic            w_err_set;
  logic [2:0]      w_err_stage_nxt;
  logic            w_all_done_set;

  // Once the stage count reaches N_FLAGS the shift clears every bit. No done
  // code can then match the current stage.
  assign w_stage_oh = ONE_N << r_stage;
  assign w_inorder  = |(w_done_vec & w_stage_oh);

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_RUN;
      r_stage <= '0;
    end else if (i_clear) begin
      r_state <= S_RUN;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stage_nxt     = r_stage;
    w_set           = '0;
    w_evt           = 1'b0;
    w_evt_oh        = '0;
    w_evt_code      = 4'h5;
    w_err_set       = 1'b0;
    w_err_stage_nxt = 3'd0;
    w_all_done_set  = 1'b0;

    if (i_done && !i_clear) begin
      unique case (r_state)
        S_RUN: begin
          w_evt = 1'b1;
          if (w_done_hit) begin
            w_evt_oh = w_done_vec;
            if (w_inorder) begin
              w_set       = w_done_vec;
              w_evt_code  = 4'hA;
              w_stage_nxt = r_stage + SW'(1);
              if (r_stage == STAGE_LAST) begin
                w_state_nxt    = S_COMPLETE;
                w_all_done_set = 1'b1;
              end
            end else begin
              w_evt_code      = 4'hE;
              w_state_nxt     = S_ERROR;
              w_err_set       = 1'b1;
              w_err_stage_nxt = 3'(r_stage);
            end
          end else if (w_fail_hit) begin
            w_evt_oh        = w_fail_vec;
            w_state_nxt     = S_ERROR;
            w_err_set       = 1'b1;
            w_err_stage_nxt = w_fail_idx;
          end
          // Any other byte reports {HDR, 0, 5} and leaves the sequence alone.
        end
        S_COMPLETE: begin
          w_evt = 1'b1;
        end
        default: ; // ERROR: strobes ignored until clear
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Latched results and the one-deep status link
  // ---------------------------------------------------------------------------
  logic            r_all_done, r_err;
  logic [2:0]      r_err_stage;
  logic [STW-1:0]  r_status;
  logic            r_valid, r_ovf;
  logic [STW-1:0]  w_word;

  assign w_word = {STATUS_HDR, w_evt_oh, w_evt_code};

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_all_done  <= 1'b0;
      r_err       <= 1'b0;
      r_err_stage <= 3'd0;
      r_status    <= '0;
      r_valid     <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (i_clear) begin
      // The status word is left as it was. It is meaningless while valid=0.
      r_all_done  <= 1'b0;
      r_err       <= 1'b0;
      r_err_stage <= 3'd0;
      r_valid     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_all_done_set) r_all_done <= 1'b1;
      if (w_err_set) begin
        r_err       <= 1'b1;
        r_err_stage <= w_err_stage_nxt;
      end
      // A held word is frozen until it is taken. A new event that lands in
      // the same cycle as a transfer replaces the word without loss.
      if (w_evt) begin
        if (!r_valid || i_status_ready) begin
          r_status <= w_word;
          r_valid  <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && i_status_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_flags        = w_flags;
  assign o_all_done     = r_all_done;
  assign o_err          = r_err;
  assign o_err_stage    = r_err_stage;
  assign o_status       = r_status;
  assign o_status_valid = r_valid;
  assign o_status_ovf   = r_ovf;
endmodule

// File: tb/tb_flag_sequencer.sv
// -----------------------------------------------------------------------------
// tb_flag_sequencer
//   Two instances share one clock:
//     u0: defaults (N_FLAGS=4, sticky flags)
//     u1: N_FLAGS=2, pulse flags
//   A behavioural model tracks progress as "stages completed so far". The
//   status link is modelled as a single pending word. One negedge process
//   compares both DUTs against the model on every cycle. Directed tests add
//   literal expectations that pin the model.
//   Status literals are the field concatenation {HDR, onehot, code}. For the
//   14-bit instance, {8'h01, 2'b01, 4'hA} = 14'h05A.
// -----------------------------------------------------------------------------
module tb_flag_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] d0, d1;
  logic       dn0, dn1, clr0, clr1, rdy0, rdy1;

  logic [3:0]  flags0;  logic [1:0] flags1;
  logic        ad0, ad1, er0, er1, sv0, sv1, ov0, ov1;
  logic [2:0]  es0, es1;
  logic [15:0] st0;     logic [13:0] st1;

  flag_sequencer u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d0), .i_done(dn0), .i_clear(clr0),
    .o_flags(flags0), .o_all_done(ad0), .o_err(er0), .o_err_stage(es0),
    .o_status(st0), .o_status_valid(sv0), .i_status_ready(rdy0), .o_status_ovf(ov0)
  );

  flag_sequencer #(.N_FLAGS(2), .STICKY(1'b0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d1), .i_done(dn1), .i_clear(clr1),
    .o_flags(flags1), .o_all_done(ad1), .o_err(er1), .o_err_stage(es1),
    .o_status(st1), .o_status_valid(sv1), .i_status_ready(rdy1), .o_status_ovf(ov1)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_n[2]      = '{4, 2};
  bit m_sticky[2] = '{1'b1, 1'b0};
  int m_pos[2], m_errst[2], m_sw[2], m_pulse[2], m_hold[2];
  bit m_complete[2], m_err[2], m_sv[2], m_ovf[2];

  function automatic int word(input int k, input int oh, input int code);
    return (1 << (m_n[k] + 4)) | (oh << 4) | code;
  endfunction

  function automatic int exp_flags(input int k);
    return m_sticky[k] ? ((1 << m_pos[k]) - 1) : m_pulse[k];
  endfunction

  task automatic model_reset(input int k);
    m_pos[k] = 0; m_errst[k] = 0; m_sw[k] = 0; m_pulse[k] = 0; m_hold[k] = 0;
    m_complete[k] = 0; m_err[k] = 0; m_sv[k] = 0; m_ovf[k] = 0;
  endtask

  task automatic model_step(input int k, input logic [7:0] d, input logic dn,
                            input logic clr, input logic rdy);
    int di, fi, w;
    bit have;
    if (!rst_n) return;
    if (m_hold[k] > 0) begin m_hold[k]--; return; end
    if (clr) begin
      m_pos[k] = 0; m_errst[k] = 0; m_pulse[k] = 0;
      m_complete[k] = 0; m_err[k] = 0; m_sv[k] = 0; m_ovf[k] = 0;
      return;
    end
    m_pulse[k] = 0;
    have = 0; w = 0;
    di = int'(d) - 'h52;
    fi = int'(d) - 'h56;
    if (dn && !m_err[k]) begin
      have = 1;
      if (m_complete[k]) w = word(k, 0, 'h5);
      else if (di >= 0 && di < m_n[k]) begin
        if (di == m_pos[k]) begin
          m_pos[k]++;
          m_pulse[k] = 1 << di;
          w = word(k, 1 << di, 'hA);
          if (m_pos[k] == m_n[k]) m_complete[k] = 1;
        end else begin
          m_err[k] = 1; m_errst[k] = m_pos[k];
          w = word(k, 1 << di, 'hE);
        end
      end else if (fi >= 0 && fi < m_n[k]) begin
        m_err[k] = 1; m_errst[k] = fi;
        w = word(k, 1 << fi, 'h5);
      end else w = word(k, 0, 'h5);
    end
    if (have) begin
      if (!m_sv[k] || rdy) begin m_sw[k] = w; m_sv[k] = 1; end
      else m_ovf[k] = 1;
    end else if (m_sv[k] && rdy) m_sv[k] = 0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0.flags",     32'(flags0), exp_flags(0));
      chk("u0.all_done",  32'(ad0),    32'(m_complete[0]));
      chk("u0.err",       32'(er0),    32'(m_err[0]));
      chk("u0.err_stage", 32'(es0),    m_errst[0]);
      chk("u0.valid",     32'(sv0),    32'(m_sv[0]));
      chk("u0.ovf",       32'(ov0),    32'(m_ovf[0]));
      if (m_sv[0]) chk("u0.status", 32'(st0), m_sw[0]);
      chk("u1.flags",     32'(flags1), exp_flags(1));
      chk("u1.all_done",  32'(ad1),    32'(m_complete[1]));
      chk("u1.err",       32'(er1),    32'(m_err[1]));
      chk("u1.err_stage", 32'(es1),    m_errst[1]);
      chk("u1.valid",     32'(sv1),    32'(m_sv[1]));
      chk("u1.ovf",       32'(ov1),    32'(m_ovf[1]));
      if (m_sv[1]) chk("u1.status", 32'(st1), m_sw[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    model_step(0, d0, dn0, clr0, rdy0);
    model_step(1, d1, dn1, clr1, rdy1);
    @(negedge clk);
  endtask

  task automatic send0(input logic [7:0] b);
    d0 = b; dn0 = 1'b1; step(); dn0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    d1 = b; dn1 = 1'b1; step(); dn1 = 1'b0;
  endtask

  task automatic clear0();
    clr0 = 1'b1; step(); clr0 = 1'b0;
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, ".flags"},  32'(flags0), 0);
    chk({tag, ".alldn"},  32'(ad0),    0);
    chk({tag, ".err"},    32'(er0),    0);
    chk({tag, ".estg"},   32'(es0),    0);
    chk({tag, ".status"}, 32'(st0),    0);
    chk({tag, ".valid"},  32'(sv0),    0);
    chk({tag, ".ovf"},    32'(ov0),    0);
  endtask

  // Assert reset between edges, check that the outputs clear at once, then
  // release it and let the synchroniser finish its two edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset(0); model_reset(1);
    #1 chk_zero0("T1.rst");
    chk("T1.rst.u1flags", 32'(flags1), 0);
    step();
    #2 rst_n = 1'b1;
    m_hold[0] = 2; m_hold[1] = 2;
    step(); step();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b1;
    d0 = '0; d1 = '0; dn0 = 0; dn1 = 0; clr0 = 0; clr1 = 0; rdy0 = 1; rdy1 = 1;
    model_reset(0); model_reset(1);
    #1 rst_n = 1'b0;
    #1 chk_zero0("T0.rst");
    chk_en = 1'b1;
    #2 rst_n = 1'b1;
    m_hold[0] = 2; m_hold[1] = 2;
    step(); step();

    // T1: reset in the middle of a sequence, then restart
    send0(8'h52); send0(8'h53);
    chk("T1.mid.flags", 32'(flags0), 32'h3);
    do_reset();
    send0(8'h52);
    chk("T1.flags", 32'(flags0), 32'h1);

    // T2: every stage in order with ready=1
    clear0();
    send0(8'h52); chk("T2.st0", 32'(st0), 32'h011A);
    send0(8'h53); chk("T2.st1", 32'(st0), 32'h012A);
    send0(8'h54); chk("T2.st2", 32'(st0), 32'h014A);
    chk("T2.notdone", 32'(ad0), 0);
    send0(8'h55); chk("T2.st3", 32'(st0), 32'h018A);
    chk("T2.flags", 32'(flags0), 32'hF);
    chk("T2.alldone", 32'(ad0), 1);
    send0(8'h52); chk("T2.complete", 32'(st0), 32'h0105);
    chk("T2.flagshold", 32'(flags0), 32'hF);

    // T3: a stage done out of order
    clear0();
    send0(8'h52); chk("T3.st0", 32'(st0), 32'h011A);
    send0(8'h54); chk("T3.st1", 32'(st0), 32'h014E);
    chk("T3.err", 32'(er0), 1);
    chk("T3.estg", 32'(es0), 1);
    send0(8'h53);
    chk("T3.ignored.flags", 32'(flags0), 32'h1);
    chk("T3.ignored.st", 32'(st0), 32'h014E);

    // T4: stage fail, then clear
    clear0();
    send0(8'h52); send0(8'h53); send0(8'h58);
    chk("T4.st", 32'(st0), 32'h0145);
    chk("T4.estg", 32'(es0), 2);
    clear0();
    send0(8'h52);
    chk("T4.flags", 32'(flags0), 32'h1);
    chk("T4.err", 32'(er0), 0);

    // An unknown byte in RUN
    send0(8'h00);
    chk("T4b.st", 32'(st0), 32'h0105);
    chk("T4b.flags", 32'(flags0), 32'h1);

    // Boundaries of the fail range: 5A is just past it, 59 is the last stage's fail
    clear0();
    send0(8'h5A);
    chk("B.5A.st", 32'(st0), 32'h0105);
    chk("B.5A.err", 32'(er0), 0);
    send0(8'h59);
    chk("B.59.st", 32'(st0), 32'h0185);
    chk("B.59.estg", 32'(es0), 3);

    // clear in the same cycle as done discards the byte
    clear0();
    send0(8'h52);
    d0 = 8'h53; dn0 = 1'b1; clr0 = 1'b1; step(); dn0 = 1'b0; clr0 = 1'b0;
    chk("C.flags", 32'(flags0), 0);
    chk("C.valid", 32'(sv0), 0);
    send0(8'h52);
    chk("C.restart", 32'(flags0), 32'h1);

    // T5: backpressure drops the second word
    clear0();
    rdy0 = 1'b0;
    send0(8'h52); chk("T5.st0", 32'(st0), 32'h011A);
    send0(8'h53); chk("T5.hold", 32'(st0), 32'h011A);
    chk("T5.ovf", 32'(ov0), 1);
    chk("T5.flags", 32'(flags0), 32'h3);
    rdy0 = 1'b1; step();
    chk("T5.drained", 32'(sv0), 0);
    chk("T5.ovfsticky", 32'(ov0), 1);

    // An event in the same cycle as a transfer loads without overflow
    clear0();
    rdy0 = 1'b0;
    send0(8'h52);
    rdy0 = 1'b1;
    send0(8'h53);
    chk("T5b.st", 32'(st0), 32'h012A);
    chk("T5b.valid", 32'(sv0), 1);
    chk("T5b.ovf", 32'(ov0), 0);
    step();

    // T6: two stages, pulse flags, 14-bit status
    send1(8'h52);
    chk("T6.p0", 32'(flags1), 32'h1);
    chk("T6.st0", 32'(st1), 32'h05A);
    step();
    chk("T6.p0off", 32'(flags1), 0);
    send1(8'h53);
    chk("T6.p1", 32'(flags1), 32'h2);
    chk("T6.st1", 32'(st1), 32'h06A);
    chk("T6.alldone", 32'(ad1), 1);
    step();
    chk("T6.p1off", 32'(flags1), 0);
    chk("T6.alldonelvl", 32'(ad1), 1);

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
